exe_unit: RTL and testbench
===========================

# exe_unit

Execute-stage consumer of the decode controller's `alu_ctrl`, `mux3_sel` and `mux4_sel` outputs.
- Selects ALU operands, performs the RV32IM integer operation, and registers the result toward the memory stage.
- Single-cycle for RV32I ops; multicycle iterative path for multiply ops.
- valid/ready handshake on both sides, so the pipeline stalls cleanly while a multiply runs or downstream back-pressures.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 is verified).
- `MUL_CYCLES`, 32, iterations of the shift-add multiplier (equals `XLEN`).

Ports:
- `clk`  input  1  clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  decode stage presents an operation.
- `in_ready`  output  1  unit accepts the operation this cycle.
- `alu_ctrl`  input  4  operation code (package encoding).
- `mux3_sel`  input  1  src1 select: 0 = `rs1_data`, 1 = `pc`.
- `mux4_sel`  input  1  src2 select: 0 = `rs2_data`, 1 = `imm`.
- `rs1_data`, `rs2_data`, `pc`, `imm`  input  XLEN each  operand sources.
- `rd_addr`  input  5  destination register tag, carried with the result.
- `out_valid`  output  1  result register holds a valid result.
- `out_ready`  input  1  memory stage consumes the result.
- `out_result`  output  XLEN  registered result.
- `out_rd`  output  5  registered destination tag.

## Operation
- Operand selection: `op1 = mux3_sel ? pc : rs1_data`; `op2 = mux4_sel ? imm : rs2_data`.
- `alu_ctrl` encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 PASSB (result = op2, for LUI).
  - 15 reserved; result is 0.
- Shift amount is `op2[4:0]`. SLT/SLTU produce 1 or 0. ADD/SUB wrap modulo 2^32.
- Multiply, magnitude based:
  - op1 is signed for MUL/MULH/MULHSU; op2 is signed for MUL/MULH.
  - Form unsigned magnitudes and run 32 shift-add iterations into a 64-bit accumulator.
  - Negate the accumulator if the operand signs differ.
  - MUL returns the low 32 bits; all others return the high 32 bits.
  - −2^31 × −2^31 must yield 0x4000_0000_0000_0000.
- FSM states:
  - IDLE: accepts operations.
  - MUL: iterating; `in_ready` = 0.
  - A non-multiply accept stays in IDLE.
  - A multiply accept goes to MUL with the counter at 0.
  - MUL returns to IDLE when the counter reaches `MUL_CYCLES-1` and the result is loaded.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`. Combinational; it never depends on `in_valid`.
- Output register:
  - Loaded on accept (single-cycle op) or at MUL completion.
  - Holds `out_result` and `out_rd` stable while `out_valid && !out_ready`.
  - `out_valid` clears on `out_ready` unless a new result loads in the same cycle.
- MUL completion while the previous result is still unconsumed cannot occur: entry to MUL already required a free or draining output register.

## Timing
- Reset values:
  - `out_valid` = 0, `out_result` = 0, `out_rd` = 0.
  - State IDLE, iteration counter 0, accumulator 0.
  - `in_ready` = 1 immediately after reset.
- Single-cycle op accepted at edge N: `out_valid` = 1 after edge N.
- Multiply accepted at edge N: iterations on edges N+1..N+32; `out_valid` = 1 after edge N+32.
- Back-to-back: with `out_ready` held high, single-cycle ops sustain 1 per clock.
- Simultaneous consume and accept: the output reloads in the same edge and `out_valid` stays 1.
- Reset asserted mid-multiply aborts it: all state returns to reset values asynchronously, and no partial result is emitted.
- Operand and `alu_ctrl` inputs are sampled only at the accepting edge. Changes while in MUL are ignored.

## Structure
- Shared package `exe_pkg`:
  - `alu_op_e` enum with the encoding above.
  - `exe_state_e` {IDLE, MUL}.
  - The mux-select constants `SRC1_RS1`/`SRC1_PC` and `SRC2_RS2`/`SRC2_IMM`.
  - The decode controller uses the same package.
- One sub-module, `iter_mul`: start pulse, operands, signedness flags; outputs `done` and a 64-bit product. All other logic is flat in `exe_unit`.

## Test plan
- Reset with `in_valid` = 1 → `out_valid` = 0, `out_result` = 0, `in_ready` = 1. Release reset, issue ADD 5 + 7 (`mux4_sel` = 0) → next cycle `out_result` = 12, `out_rd` echoed.
- Operand mux: `mux3_sel` = 1, `pc` = 0x100, `mux4_sel` = 1, `imm` = 0x20, ADD → 0x120. SRA with 0x8000_0000 by 4 → 0xF800_0000.
- MULH with −2^31 × −2^31 → `in_ready` = 0 for 32 cycles; `out_valid` rises 32 clocks after accept with 0x4000_0000. MULHU 0xFFFF_FFFF × 2 → 1. MUL −3 × 7 → 0xFFFF_FFEB.
- Back-pressure: `out_ready` = 0 after an ADD result → `in_ready` = 0, result held stable 5 cycles. Raise `out_ready` together with a new `in_valid` → new result follows in the next cycle with no bubble.
- Reset at cycle 10 of a multiply → `out_valid` never asserts for it. The next ADD 1 + 1 → 2 after one clock.
- Reserved `alu_ctrl` = 15 → `out_result` = 0 after one clock. SLT −1 < 1 → 1; SLTU 0xFFFF_FFFF < 1 → 0.

Source files
------------

// File: rtl/exe_pkg.sv
// exe_pkg: shared execute-stage types and constants.
// ALU op encoding, FSM states and operand-mux select values.
package exe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_MUL    = 4'd10,
        ALU_MULH   = 4'd11,
        ALU_MULHSU = 4'd12,
        ALU_MULHU  = 4'd13,
        ALU_PASSB  = 4'd14,
        ALU_RSVD   = 4'd15
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exe_state_e;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

    function automatic logic is_mul_op(input alu_op_e op);
        return (op == ALU_MUL)    || (op == ALU_MULH) ||
               (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/exe_unit_if.sv
// exe_unit_if: decode->execute request and execute->memory result
// handshakes. master = producer/consumer side, slave = exe_unit.
interface exe_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic            mux3_sel;
    logic            mux4_sel;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;

    modport master (
        output in_valid, alu_ctrl, mux3_sel, mux4_sel,
        output rs1_data, rs2_data, pc, imm, rd_addr,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, alu_ctrl, mux3_sel, mux4_sel,
        input  rs1_data, rs2_data, pc, imm, rd_addr,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd
    );

endinterface

// File: rtl/exe_unit_iter_mul.sv
// iter_mul: magnitude-based shift-add multiplier, one bit per clock.
// Ports: clk, rst, start_i, a_i/b_i, a_signed_i/b_signed_i, done_o, product_o.
module iter_mul #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic              a_signed_i,
    input  logic              b_signed_i,
    output logic              done_o,
    output logic [2*XLEN-1:0] product_o
);

    localparam int CW = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic              neg_q;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] acc_sum;

    assign a_neg = a_signed_i & a_i[XLEN-1];
    assign b_neg = b_signed_i & b_i[XLEN-1];
    assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
    assign b_mag = b_neg ? (~b_i + 1'b1) : b_i;

    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // The final iteration's sum is presented combinationally so the
    // caller can register the product on the same edge.
    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = neg_q ? (~acc_sum + 1'b1) : acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= a_neg ^ b_neg;
        end else if (busy_q) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/exe_unit.sv
// exe_unit: execute stage; operand muxing, RV32IM ALU, iterative multiply,
// registered result. Ports: clk, rst, bus (exe_unit_if.slave).
module exe_unit
    import exe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    exe_unit_if.slave  bus
);

    exe_state_e        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              mul_lo_q, mul_lo_d;
    logic [4:0]        mul_rd_q, mul_rd_d;

    alu_op_e           op;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   alu_res;
    logic              op_is_mul;
    logic              in_ready;
    logic              accept;
    logic              mul_start;
    logic              a_signed;
    logic              b_signed;
    logic              mul_done;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;

    assign op    = alu_op_e'(bus.alu_ctrl);
    assign op1   = (bus.mux3_sel == SRC1_PC)  ? bus.pc  : bus.rs1_data;
    assign op2   = (bus.mux4_sel == SRC2_IMM) ? bus.imm : bus.rs2_data;
    assign shamt = op2[4:0];

    always_comb begin
        alu_res = '0;
        unique case (op)
            ALU_ADD:   alu_res = op1 + op2;
            ALU_SUB:   alu_res = op1 - op2;
            ALU_SLL:   alu_res = op1 << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}},
                                  ($signed(op1) < $signed(op2))};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:   alu_res = op1 ^ op2;
            ALU_SRL:   alu_res = op1 >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(op1) >>> shamt);
            ALU_OR:    alu_res = op1 | op2;
            ALU_AND:   alu_res = op1 & op2;
            ALU_PASSB: alu_res = op2;
            default:   alu_res = '0;
        endcase
    end

    assign op_is_mul = is_mul_op(op);
    assign a_signed  = (op == ALU_MUL) || (op == ALU_MULH) ||
                       (op == ALU_MULHSU);
    assign b_signed  = (op == ALU_MUL) || (op == ALU_MULH);

    assign in_ready  = (state_q == IDLE) &&
                       (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign mul_start = accept && op_is_mul;

    iter_mul #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start_i    (mul_start),
        .a_i        (op1),
        .b_i        (op2),
        .a_signed_i (a_signed),
        .b_signed_i (b_signed),
        .done_o     (mul_done),
        .product_o  (mul_prod)
    );

    assign mul_res = mul_lo_q ? mul_prod[XLEN-1:0]
                              : mul_prod[2*XLEN-1:XLEN];

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        mul_lo_d     = mul_lo_q;
        mul_rd_d     = mul_rd_q;

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept && op_is_mul) begin
                    state_d  = MUL;
                    mul_lo_d = (op == ALU_MUL);
                    mul_rd_d = bus.rd_addr;
                end else if (accept) begin
                    out_valid_d  = 1'b1;
                    out_result_d = alu_res;
                    out_rd_d     = bus.rd_addr;
                end
            end
            MUL: begin
                // Entry required a free or draining output register,
                // so completion can always load it.
                if (mul_done) begin
                    state_d      = IDLE;
                    out_valid_d  = 1'b1;
                    out_result_d = mul_res;
                    out_rd_d     = mul_rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            mul_lo_q     <= 1'b0;
            mul_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            mul_lo_q     <= mul_lo_d;
            mul_rd_q     <= mul_rd_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_rd     = out_rd_q;

endmodule

// File: tb/tb_exe_unit.sv
// tb_exe_unit: directed self-checking bench for exe_unit.
// Inputs driven #1 after posedge; outputs sampled at the same point.
module tb_exe_unit;
    import exe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    exe_unit_if #(.XLEN(32)) bus ();

    exe_unit #(
        .XLEN       (32),
        .MUL_CYCLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.alu_ctrl = op;
        bus.mux3_sel = SRC1_RS1;
        bus.mux4_sel = SRC2_RS2;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.pc       = 32'h0;
        bus.imm      = 32'h0;
        bus.rd_addr  = rd;
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        drive(ALU_ADD, 32'd9, 32'd9, 5'd1);
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 ||
            bus.out_rd !== 5'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b res=%h rd=%0d rdy=%b exp 0 0 0 1",
                     bus.out_valid, bus.out_result, bus.out_rd,
                     bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_add();
        drive(ALU_ADD, 32'd5, 32'd7, 5'd3);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12 ||
            bus.out_rd !== 5'd3) begin
            errors++;
            $display("FAIL add: valid=%b res=%h rd=%0d exp 1 0000000c 3",
                     bus.out_valid, bus.out_result, bus.out_rd);
        end
    endtask

    task automatic test_operand_mux();
        drive(ALU_ADD, 32'hDEAD, 32'h55, 5'd4);
        bus.mux3_sel = SRC1_PC;
        bus.mux4_sel = SRC2_IMM;
        bus.pc       = 32'h100;
        bus.imm      = 32'h20;
        tick();
        checks++;
        if (bus.out_result !== 32'h120 || bus.out_rd !== 5'd4) begin
            errors++;
            $display("FAIL mux_add: res=%h rd=%0d exp 00000120 4",
                     bus.out_result, bus.out_rd);
        end
        drive(ALU_SRA, 32'h8000_0000, 32'h0, 5'd5);
        bus.mux4_sel = SRC2_IMM;
        bus.imm      = 32'd4;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_result !== 32'hF800_0000) begin
            errors++;
            $display("FAIL mux_sra: res=%h exp f8000000", bus.out_result);
        end
    endtask

    task automatic test_multiply();
        int n;
        drive(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 5'd7);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mulh_busy0: in_ready=%b exp 0", bus.in_ready);
        end
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i < 32) begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL mulh_busy%0d: valid=%b rdy=%b exp 0 0",
                             i, bus.out_valid, bus.in_ready);
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b1 ||
                    bus.out_result !== 32'h4000_0000 ||
                    bus.out_rd !== 5'd7) begin
                    errors++;
                    $display("FAIL mulh_min: valid=%b res=%h rd=%0d exp 1 40000000 7",
                             bus.out_valid, bus.out_result, bus.out_rd);
                end
            end
        end

        drive(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd8);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || n != 32 ||
            bus.out_result !== 32'h1 || bus.out_rd !== 5'd8) begin
            errors++;
            $display("FAIL mulhu: valid=%b cyc=%0d res=%h exp 1 32 00000001",
                     bus.out_valid, n, bus.out_result);
        end

        drive(ALU_MUL, 32'hFFFF_FFFD, 32'd7, 5'd9);
        tick();
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALU_ADD;
        bus.rs1_data = 32'h1234_5678;
        bus.rs2_data = 32'h0BAD_F00D;
        bus.rd_addr  = 5'd30;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || n != 32 ||
            bus.out_result !== 32'hFFFF_FFEB || bus.out_rd !== 5'd9) begin
            errors++;
            $display("FAIL mul_neg: valid=%b cyc=%0d res=%h rd=%0d exp 1 32 ffffffeb 9",
                     bus.out_valid, n, bus.out_result, bus.out_rd);
        end
        tick();
    endtask

    task automatic test_backpressure();
        drive(ALU_ADD, 32'd2, 32'd3, 5'd4);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd5 ||
                bus.out_rd !== 5'd4 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b res=%h rd=%0d rdy=%b exp 1 5 4 0",
                         i, bus.out_valid, bus.out_result, bus.out_rd,
                         bus.in_ready);
            end
            tick();
        end
        drive(ALU_ADD, 32'd10, 32'd20, 5'd6);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_rdy: in_ready=%b exp 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd30 ||
            bus.out_rd !== 5'd6) begin
            errors++;
            $display("FAIL no_bubble: valid=%b res=%h rd=%0d exp 1 1e 6",
                     bus.out_valid, bus.out_result, bus.out_rd);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        drive(ALU_MUL, 32'd3, 32'd4, 5'd10);
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_rst: valid=%b rdy=%b exp 0 1",
                     bus.out_valid, bus.in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: valid cycles=%0d exp 0", seen);
        end
        drive(ALU_ADD, 32'd1, 32'd1, 5'd11);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2 ||
            bus.out_rd !== 5'd11) begin
            errors++;
            $display("FAIL post_abort: valid=%b res=%h rd=%0d exp 1 2 11",
                     bus.out_valid, bus.out_result, bus.out_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [12] = '{
            4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd8,
            4'd9, 4'd14, 4'd15, 4'd3, 4'd4, 4'd0};
        logic [31:0] av [12] = '{
            32'd5, 32'd1, 32'd3, 32'hF0F0, 32'h8000_0000, 32'hF0,
            32'hF0, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF};
        logic [31:0] bv [12] = '{
            32'd7, 32'd31, 32'h21, 32'hFF00, 32'd4, 32'h0F,
            32'h3C, 32'h1234_5000, 32'd6, 32'd1, 32'd1, 32'd2};
        logic [31:0] ev [12] = '{
            32'hFFFF_FFFE, 32'h8000_0000, 32'd6, 32'h0FF0,
            32'h0800_0000, 32'hFF, 32'h30, 32'h1234_5000, 32'h0,
            32'd1, 32'd0, 32'd1};
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], av[i], bv[i], 5'(i + 12));
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== ev[i] ||
                bus.out_rd !== 5'(i + 12)) begin
                errors++;
                $display("FAIL b2b_op%0d: valid=%b res=%h rd=%0d exp 1 %h %0d",
                         ops[i], bus.out_valid, bus.out_result,
                         bus.out_rd, ev[i], i + 12);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(ALU_ADD, 32'h0, 32'h0, 5'd0);
        bus.in_valid = 1'b0;
        test_reset();
        test_add();
        test_operand_mux();
        test_multiply();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
